// File: rtl/adder4_result_buffer_if.sv
// Result-buffer bus: adder results in on a valid/ready push side,
// buffered entries out on a valid/ready pop side, plus status.
interface adder4_result_buffer_if #(
    parameter int LVL_W = 3
);
    // Push side: adder result and its handshake
    logic [3:0]       sum;
    logic             cout;
    logic             in_valid;
    logic             in_ready;

    // Pop side: head entry {cout, sum} and its handshake
    logic [4:0]       out_data;
    logic             out_valid;
    logic             out_ready;

    // Status and control
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             clr_ovf;

    // Producer/consumer view (drives results, consumes entries)
    modport master (
        output sum,
        output cout,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  level,
        input  ovf,
        output clr_ovf
    );

    // Buffer view
    modport slave (
        input  sum,
        input  cout,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output level,
        output ovf,
        input  clr_ovf
    );
endinterface

// File: rtl/adder4_result_buffer.sv
// adder4_result_buffer: small show-ahead FIFO that captures {cout, sum}
// results from the 4-bit adder and hands them out over valid/ready.
// Full/empty status comes from a registered level count, so in_ready
// never depends combinationally on out_ready. A push while full is
// dropped and latches the sticky ovf flag.
module adder4_result_buffer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    adder4_result_buffer_if.slave  bus
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    // Registered state
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             ovf_reg;

    // Next-state values
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [LVL_W-1:0] level_next;
    logic             ovf_next;

    // Entry storage; only the head entry is ever observed, and it is
    // masked to zero while empty, so the array itself needs no reset.
    logic [4:0]       mem [DEPTH];

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             reject;
    logic [4:0]       wr_data;
    logic [DEPTH-1:0] wr_sel;

    // Status decoded purely from the registered level
    assign full    = (level_reg == FULL_LVL);
    assign empty   = (level_reg == '0);

    // Handshake qualification: a full buffer refuses pushes even if a
    // pop happens on the same edge; an empty buffer ignores out_ready.
    assign push    = bus.in_valid  & ~full;
    assign pop     = bus.out_ready & ~empty;
    assign reject  = bus.in_valid  &  full;
    assign wr_data = {bus.cout, bus.sum};

    // One-hot write select per storage slot
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Pointer, level and overflow next-state logic
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        ovf_next    = ovf_reg;

        // Pointers are power-of-two wide, so +1 wraps DEPTH-1 -> 0
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   level_next = level_reg + LVL_ONE;
            2'b01:   level_next = level_reg - LVL_ONE;
            default: level_next = level_reg;
        endcase

        // Set beats clear when both happen on the same edge
        if (reject) begin
            ovf_next = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Storage write: the selected slot captures {cout, sum}
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Outputs: show-ahead head entry straight from storage, zero when empty
    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 5'b00000 : mem[rd_ptr_reg];
    assign bus.level     = level_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_adder4_result_buffer.sv
// Directed bench for adder4_result_buffer: reset, single entry, fill and
// overflow, full with simultaneous push/pop, streaming across pointer
// wrap, and reset in the middle of traffic.
module tb_adder4_result_buffer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    adder4_result_buffer_if #(.LVL_W(3)) bus ();

    adder4_result_buffer #(
        .DEPTH (4),
        .LVL_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] d, input logic v);
        bus.cout     = d[4];
        bus.sum      = d[3:0];
        bus.in_valid = v;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst          = 1'b0;
        bus.sum      = 4'h0;
        bus.cout     = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready= 1'b0;
        bus.clr_ovf  = 1'b0;

        // ---- Reset then idle: outputs respond to rst without a clock edge
        step();
        #2;
        rst = 1'b1;
        #1;
        check("rst_level",     8'(bus.level),     8'd0);
        check("rst_out_valid", 8'(bus.out_valid), 8'd0);
        check("rst_in_ready",  8'(bus.in_ready),  8'd1);
        check("rst_ovf",       8'(bus.ovf),       8'd0);
        check("rst_out_data",  8'(bus.out_data),  8'h00);
        step();
        rst = 1'b0;
        step();
        check("idle_level",    8'(bus.level),     8'd0);
        check("idle_out_valid",8'(bus.out_valid), 8'd0);

        // ---- Single result
        drive(5'h1A, 1'b1);
        step();
        drive(5'h00, 1'b0);
        check("single_valid",  8'(bus.out_valid), 8'd1);
        check("single_data",   8'(bus.out_data),  8'h1A);
        check("single_level",  8'(bus.level),     8'd1);
        bus.out_ready = 1'b1;
        step();
        check("single_pop_lvl",8'(bus.level),     8'd0);
        check("single_pop_vld",8'(bus.out_valid), 8'd0);
        // empty buffer ignores out_ready
        step();
        check("empty_pop_lvl", 8'(bus.level),     8'd0);
        bus.out_ready = 1'b0;

        // ---- Fill and overflow
        for (int i = 1; i <= 4; i++) begin
            drive(5'(i), 1'b1);
            step();
        end
        check("fill_level",    8'(bus.level),     8'd4);
        check("fill_in_ready", 8'(bus.in_ready),  8'd0);
        check("fill_head",     8'(bus.out_data),  8'h01);
        drive(5'h05, 1'b1);
        step();
        drive(5'h00, 1'b0);
        check("ovf_set",       8'(bus.ovf),       8'd1);
        check("ovf_level",     8'(bus.level),     8'd4);
        check("ovf_head_hold", 8'(bus.out_data),  8'h01);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 8'(bus.out_data), 8'(i));
            step();
        end
        bus.out_ready = 1'b0;
        check("drain_level",   8'(bus.level),     8'd0);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check("ovf_clear",     8'(bus.ovf),       8'd0);

        // ---- Full with simultaneous push/pop: push rejected, pop happens
        for (int i = 1; i <= 4; i++) begin
            drive(5'(8'h10 + i), 1'b1);
            step();
        end
        drive(5'h15, 1'b1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("fullpp_level",  8'(bus.level),     8'd3);
        check("fullpp_ovf",    8'(bus.ovf),       8'd1);
        check("fullpp_head",   8'(bus.out_data),  8'h12);
        drive(5'h16, 1'b1);
        step();
        check("refill_level",  8'(bus.level),     8'd4);
        // set and clear on the same edge: set wins
        drive(5'h17, 1'b1);
        bus.clr_ovf = 1'b1;
        step();
        drive(5'h00, 1'b0);
        check("set_wins_ovf",  8'(bus.ovf),       8'd1);
        step();
        bus.clr_ovf = 1'b0;
        check("clr_ovf",       8'(bus.ovf),       8'd0);
        bus.out_ready = 1'b1;
        check("fpp_drain0",    8'(bus.out_data),  8'h12);
        step();
        check("fpp_drain1",    8'(bus.out_data),  8'h13);
        step();
        check("fpp_drain2",    8'(bus.out_data),  8'h14);
        step();
        check("fpp_drain3",    8'(bus.out_data),  8'h16);
        step();
        check("fpp_empty",     8'(bus.level),     8'd0);

        // ---- Streaming across pointer wrap with out_ready held high
        for (int i = 0; i < 10; i++) begin
            drive(5'(i), 1'b1);
            step();
            check("stream_data",  8'(bus.out_data),  8'(i));
            check("stream_level", 8'(bus.level),     8'd1);
        end
        drive(5'h00, 1'b0);
        step();
        check("stream_end_lvl",8'(bus.level),     8'd0);
        check("stream_ovf",    8'(bus.ovf),       8'd0);
        bus.out_ready = 1'b0;

        // ---- Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(5'(8'h08 + i), 1'b1);
            step();
        end
        drive(5'h00, 1'b0);
        check("mid_level",     8'(bus.level),     8'd3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_level",  8'(bus.level),     8'd0);
        check("midrst_valid",  8'(bus.out_valid), 8'd0);
        check("midrst_data",   8'(bus.out_data),  8'h00);
        step();
        rst = 1'b0;
        drive(5'h1F, 1'b1);
        step();
        drive(5'h00, 1'b0);
        check("post_rst_data", 8'(bus.out_data),  8'h1F);
        check("post_rst_level",8'(bus.level),     8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder4_result_buffer.md
ADDER4_RESULT_BUFFER -- requirements
Module: adder4_result_buffer

Downstream stage of the 4-bit adder: captures {cout, sum[3:0]} results into a small FIFO and hands them out over a valid/ready handshake.

Interface
REQ-001 The block SHALL expose these parameters:
- DEPTH, 4, number of result entries; power of 2, minimum 2.
- LVL_W, 3, width of the level output; SHALL equal log2(DEPTH)+1.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Ports are listed below.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous active-high reset.
- sum  input  4  adder sum result.
- cout  input  1  adder carry out.
- in_valid  input  1  sum/cout hold a result to capture.
- in_ready  output  1  buffer can accept a result this cycle.
- out_data  output  5  head entry, {cout, sum}; bit 4 = cout.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  LVL_W  number of stored entries, 0..DEPTH.
- ovf  output  1  sticky overflow flag.
- clr_ovf  input  1  synchronous clear for ovf.

Function
REQ-003 in_ready SHALL equal (level != DEPTH), decoded from registered state only, with no combinational path from out_ready.
REQ-004 A push SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; the entry written SHALL be {cout, sum} as sampled at that edge.
REQ-005 out_valid SHALL equal (level != 0); out_data SHALL present the oldest entry (show-ahead) directly from storage.
REQ-006 A pop SHALL occur on a rising clk edge when out_valid=1 and out_ready=1; the next-oldest entry SHALL appear on out_data in the following cycle.
REQ-007 Latency SHALL be 1 cycle: an entry pushed at edge N SHALL be visible with out_valid=1 after edge N. There SHALL be no same-cycle fall-through when empty.
REQ-008 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-009 When full, a push SHALL be rejected even if a pop occurs in the same cycle (no bypass). level SHALL then go to DEPTH-1.
REQ-010 When empty, out_ready SHALL be ignored, and level and pointers SHALL NOT change.
REQ-011 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0. level SHALL never exceed DEPTH or underflow below 0.
REQ-012 The rejected-push condition (in_valid=1 and in_ready=0 at an edge) SHALL set ovf on that edge, and the rejected data SHALL be discarded.
REQ-013 clr_ovf=1 SHALL clear ovf at the next edge. If clr_ovf and the set condition occur on the same edge, set SHALL win.
REQ-014 out_data SHALL NOT change while out_valid=1 and out_ready=0.

Reset
REQ-015 While rst=1, all of the following SHALL hold immediately, independent of clk:
- read and write pointers = 0;
- level = 0, out_valid = 0, in_ready = 1;
- ovf = 0, out_data = 5'b00000.
REQ-016 Reset asserted mid-operation SHALL discard all stored entries. The first edge after rst deasserts SHALL be able to accept a push.
REQ-017 Storage contents other than the entry driving out_data need not be reset.

Verification
REQ-018 The bench SHALL cover at least these scenarios:
- Reset then idle: rst pulse, no traffic -> level=0, out_valid=0, in_ready=1, ovf=0, out_data=0.
- Single result: push sum=4'hA, cout=1 with out_ready=0 -> next cycle out_valid=1, out_data=5'h1A, level=1. Assert out_ready one cycle -> level=0, out_valid=0.
- Fill and overflow: push 5'h01,5'h02,5'h03,5'h04 with out_ready=0 -> level=4, in_ready=0. Push 5'h05 -> ovf=1, level stays 4. Drain yields 01,02,03,04 in order.
- Full with simultaneous push/pop: at level=4, in_valid=1 and out_ready=1 -> level=3, entry not written, ovf=1. Then clr_ovf=1 -> ovf=0.
- Wrap and streaming: 10 pushes of 5'h00..5'h09 with out_ready=1 held -> outputs in order across pointer wrap, level stays <=1, ovf=0.
- Reset mid-stream: rst asserted with level=3 -> level=0 and out_valid=0 immediately. After release, push 5'h1F -> out_data=5'h1F next cycle.
